// File: rtl/cpu_trace_uart_tx.sv
// cpu_trace_uart_tx
//   Execution-trace producer. On each instruction-fetch strobe the CPU state
//   (PC, IR, SP, A F B C D E H L) is snapshotted and sent as one fixed byte
//   frame over an 8N1 UART. A host-side decoder rebuilds the per-instruction
//   state dump from these frames.
//
//   Frame: SYNC_BYTE, pc[15:8], pc[7:0], ir, sp[15:8], sp[7:0],
//          A, F, B, C, D, E, H, L [, checksum]
//   Optional build macro TRACE_CHECKSUM_EN appends one byte equal to the XOR
//   of every frame byte except SYNC_BYTE.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   SYNC_BYTE     first byte of every frame
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset (aborts any frame in flight)
//   enable       1 = accept snapshots; 0 = ignore trace_valid (no drop counting)
//   trace_valid  single-cycle strobe, state inputs valid
//   pc, ir, sp   program counter, instruction register, stack pointer
//   reg_a..reg_l register file bytes
//   tx           UART serial output, idle high
//   busy         frame in flight
//   dropped      strobes lost while busy, saturating at 8'hFF

module cpu_trace_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 36,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        trace_valid,
  input  logic [15:0] pc,
  input  logic [7:0]  ir,
  input  logic [15:0] sp,
  input  logic [7:0]  reg_a,
  input  logic [7:0]  reg_f,
  input  logic [7:0]  reg_b,
  input  logic [7:0]  reg_c,
  input  logic [7:0]  reg_d,
  input  logic [7:0]  reg_e,
  input  logic [7:0]  reg_h,
  input  logic [7:0]  reg_l,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  dropped
);

`ifdef TRACE_CHECKSUM_EN
  localparam int unsigned NBYTES = 15;
`else
  localparam int unsigned NBYTES = 14;
`endif

  localparam int unsigned       BAUD_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BYTE_LAST = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BAUD_W-1:0] baud_next;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_next;
  logic [3:0]        byte_idx;
  logic [3:0]        byte_next;
  logic              tx_next;
  logic              capture;
  logic              baud_done;

  // Snapshot in frame order, excluding the sync byte.
  logic [7:0] snap  [13];
  logic [7:0] frame [NBYTES];

  assign capture = (state == S_IDLE) && enable && trace_valid;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 13; i++) begin
        snap[i] <= '0;
      end
    end else if (capture) begin
      snap[0]  <= pc[15:8];
      snap[1]  <= pc[7:0];
      snap[2]  <= ir;
      snap[3]  <= sp[15:8];
      snap[4]  <= sp[7:0];
      snap[5]  <= reg_a;
      snap[6]  <= reg_f;
      snap[7]  <= reg_b;
      snap[8]  <= reg_c;
      snap[9]  <= reg_d;
      snap[10] <= reg_e;
      snap[11] <= reg_h;
      snap[12] <= reg_l;
    end
  end

`ifdef TRACE_CHECKSUM_EN
  logic [7:0] checksum;

  always_comb begin
    checksum = '0;
    for (int unsigned i = 0; i < 13; i++) begin
      checksum = checksum ^ snap[i];
    end
  end
`endif

  always_comb begin
    frame[0]  = SYNC_BYTE;
    frame[1]  = snap[0];
    frame[2]  = snap[1];
    frame[3]  = snap[2];
    frame[4]  = snap[3];
    frame[5]  = snap[4];
    frame[6]  = snap[5];
    frame[7]  = snap[6];
    frame[8]  = snap[7];
    frame[9]  = snap[8];
    frame[10] = snap[9];
    frame[11] = snap[10];
    frame[12] = snap[11];
    frame[13] = snap[12];
`ifdef TRACE_CHECKSUM_EN
    frame[14] = checksum;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      byte_idx <= byte_next;
      tx       <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    byte_next  = byte_idx;
    baud_done  = (baud_cnt == BAUD_LAST);

    unique case (state)
      S_IDLE: begin
        if (capture) begin
          state_next = S_START;
          baud_next  = '0;
          bit_next   = '0;
          byte_next  = '0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_next = S_DATA;
          baud_next  = '0;
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = S_STOP;
            bit_next   = '0;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (byte_idx == BYTE_LAST) begin
            state_next = S_IDLE;
            byte_next  = '0;
          end else begin
            state_next = S_START;
            byte_next  = byte_idx + 4'd1;
          end
        end else begin
          baud_next = baud_cnt + BAUD_W'(1);
        end
      end
    endcase

    // tx is registered from the next-state view so the line level changes
    // on the same edge as the state, without combinational glitches.
    tx_next = 1'b1;
    unique case (state_next)
      S_IDLE:  tx_next = 1'b1;
      S_START: tx_next = 1'b0;
      S_DATA:  tx_next = frame[byte_next][bit_next];
      S_STOP:  tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dropped <= '0;
    end else if (busy && enable && trace_valid && (dropped != 8'hFF)) begin
      dropped <= dropped + 8'd1;
    end
  end

endmodule

// File: tb/tb_cpu_trace_uart_tx.sv
// Bench for cpu_trace_uart_tx with CLKS_PER_BIT=4. A frame-level reference
// model predicts tx/busy/dropped each cycle; a UART receiver decodes tx and
// the decoded bytes are compared with hand-computed frames.
module tb_cpu_trace_uart_tx;

  localparam int CPB = 4;
`ifdef TRACE_CHECKSUM_EN
  localparam int FN = 15;
`else
  localparam int FN = 14;
`endif
  localparam int FLEN = FN * 10 * CPB;

  typedef logic [14:0][7:0] fr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        trace_valid = 1'b0;
  logic [15:0] pc = 16'h0150;
  logic [7:0]  ir = 8'h3E;
  logic [15:0] sp = 16'hFFFE;
  logic [7:0]  reg_a = 8'h01, reg_f = 8'hB0, reg_b = 8'h00, reg_c = 8'h13;
  logic [7:0]  reg_d = 8'h00, reg_e = 8'hD8, reg_h = 8'h01, reg_l = 8'h4D;
  logic        tx;
  logic        busy;
  logic [7:0]  dropped;

  int checks = 0;
  int failures = 0;

  cpu_trace_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trace_valid(trace_valid),
    .pc(pc), .ir(ir), .sp(sp),
    .reg_a(reg_a), .reg_f(reg_f), .reg_b(reg_b), .reg_c(reg_c),
    .reg_d(reg_d), .reg_e(reg_e), .reg_h(reg_h), .reg_l(reg_l),
    .tx(tx), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position counter, captured frame, drop count.
  int         mk = -1;
  fr_t        mf = '0;
  logic [7:0] mdrop = '0;

  function automatic fr_t build_frame();
    fr_t f;
    f[0] = 8'hA5;      f[1] = pc[15:8];  f[2] = pc[7:0];  f[3] = ir;
    f[4] = sp[15:8];   f[5] = sp[7:0];   f[6] = reg_a;    f[7] = reg_f;
    f[8] = reg_b;      f[9] = reg_c;     f[10] = reg_d;   f[11] = reg_e;
    f[12] = reg_h;     f[13] = reg_l;    f[14] = 8'h00;
    for (int k = 1; k <= 13; k++) f[14] = f[14] ^ f[k];
    return f;
  endfunction

  function automatic logic exp_tx(input int k);
    int bitpos, by, b;
    if (k < 0) return 1'b1;
    bitpos = k / CPB;
    by = bitpos / 10;
    b = bitpos % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return mf[by][b-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk <= -1;
      mdrop <= '0;
    end else if (mk >= 0) begin
      if (enable && trace_valid && mdrop != 8'hFF) mdrop <= mdrop + 8'd1;
      mk <= (mk == FLEN - 1) ? -1 : mk + 1;
    end else if (enable && trace_valid) begin
      mf <= build_frame();
      mk <= 0;
    end
  end

  always @(negedge clk) begin
    check("tx", {31'd0, tx}, {31'd0, exp_tx(mk)});
    check("busy", {31'd0, busy}, {31'd0, (mk >= 0)});
    check("dropped", {24'd0, dropped}, {24'd0, mdrop});
  end

  // UART receiver sampling mid-bit.
  int         rx_ph = -1;
  int         rx_bn;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (rst) begin
      rx_ph = -1;
    end else if (rx_ph < 0) begin
      if (tx === 1'b0) rx_ph = 0;
    end else begin
      rx_ph = rx_ph + 1;
      if (rx_ph % CPB == CPB / 2) begin
        rx_bn = rx_ph / CPB;
        if (rx_bn >= 1 && rx_bn <= 8) begin
          rx_sh[rx_bn-1] = tx;
        end else if (rx_bn == 9) begin
          check("stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(rx_sh);
          rx_ph = -1;
        end
      end
    end
  end

  logic [7:0] exp_v [15] = '{8'hA5, 8'h01, 8'h50, 8'h3E, 8'hFF, 8'hFE, 8'h01, 8'hB0,
                             8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D, 8'h58};

  task automatic check_rx(input int base, input logic [15:0] p, input logic [7:0] i,
                          input logic [7:0] cks);
    logic [7:0] e;
    for (int k = 0; k < FN; k++) begin
      e = exp_v[k];
      if (k == 1) e = p[15:8];
      if (k == 2) e = p[7:0];
      if (k == 3) e = i;
      if (k == 14) e = cks;
      if (base + k < rx_q.size()) check($sformatf("rx_byte%0d", base + k), {24'd0, rx_q[base+k]}, {24'd0, e});
      else check($sformatf("rx_missing%0d", base + k), 32'd0, 32'd1);
    end
  endtask

  // Called at a negedge; the strobe is sampled by the following posedge.
  task automatic strobe(input logic [15:0] p, input logic [7:0] i);
    pc = p;
    ir = i;
    trace_valid = 1'b1;
    @(negedge clk);
    trace_valid = 1'b0;
    pc = 16'hBEEF;
    ir = 8'h77;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    for (int i = 0; i < FLEN + 20; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n;
    wait_frame(n);
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  int n;

  initial begin
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_dropped", {24'd0, dropped}, 32'd0);
    enable = 1'b1;

    // Mid-frame reset aborts immediately.
    strobe(16'h0150, 8'h3E);
    repeat (50) @(negedge clk);
    trace_valid = 1'b1;
    repeat (3) @(negedge clk);
    trace_valid = 1'b0;
    check("drops_3", {24'd0, dropped}, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_dropped", {24'd0, dropped}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Clean frame with vector V.
    rx_q.delete();
    strobe(16'h0150, 8'h3E);
    wait_frame(n);
    check("busy_len", n, FLEN);
`ifdef TRACE_CHECKSUM_EN
    check("busy_len_lit", n, 600);
`else
    check("busy_len_lit", n, 560);
`endif
    repeat (5) @(negedge clk);
    check("tx_after", {31'd0, tx}, 32'd1);
    check("rx_count", rx_q.size(), FN);
    check_rx(0, 16'h0150, 8'h3E, 8'h58);

    // Strobe in the final stop-bit cycle is a drop, not a capture.
    strobe(16'h0150, 8'h3E);
    n = 0;
    for (int i = 0; i < FLEN + 20; i++) begin
      if (busy) n++;
      if (n == FLEN) break;
      @(negedge clk);
    end
    check("last_cycle_reached", n, FLEN);
    trace_valid = 1'b1;
    @(negedge clk);
    trace_valid = 1'b0;
    check("last_cycle_drop", {24'd0, dropped}, 32'd1);
    check("last_cycle_nocap", {31'd0, busy}, 32'd0);

    // enable=0: strobe ignored, no drop count.
    enable = 1'b0;
    strobe(16'h0150, 8'h3E);
    check("dis_busy", {31'd0, busy}, 32'd0);
    check("dis_tx", {31'd0, tx}, 32'd1);
    check("dis_dropped", {24'd0, dropped}, 32'd1);
    enable = 1'b1;
    rx_q.delete();
    strobe(16'h0150, 8'h3E);
    repeat (3 * 10 * CPB + 2 * CPB) @(negedge clk);
    enable = 1'b0;
    wait_idle();
    enable = 1'b1;
    check("en_fall_count", rx_q.size(), FN);
    check_rx(0, 16'h0150, 8'h3E, 8'h58);

    // 300 strobes while busy saturate the drop counter.
    rx_q.delete();
    strobe(16'h0150, 8'h3E);
    trace_valid = 1'b1;
    repeat (300) @(negedge clk);
    trace_valid = 1'b0;
    check("dropped_sat", {24'd0, dropped}, 32'hFF);
    wait_idle();
    check("sat_rx_count", rx_q.size(), FN);
    check_rx(0, 16'h0150, 8'h3E, 8'h58);
    rx_q.delete();
    strobe(16'h0150, 8'h3E);
    check("recapture_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check("dropped_still_sat", {24'd0, dropped}, 32'hFF);

    // Two frames back to back.
    do_reset();
    rx_q.delete();
    strobe(16'h0150, 8'h3E);
    wait_idle();
    strobe(16'h0151, 8'hC3);
    check("second_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check("two_frame_count", rx_q.size(), 2 * FN);
    check_rx(0, 16'h0150, 8'h3E, 8'h58);
    check_rx(FN, 16'h0151, 8'hC3, 8'hA4);
    check("two_frame_dropped", {24'd0, dropped}, 32'd0);

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
